// File: rtl/bt_cmd_pkg.sv
// Shared definitions for the Bluetooth command link, used by both the
// controller-side transmitter and the vehicle-side decoder.
package bt_cmd_pkg;

    localparam logic [1:0] CMD_DIR_LEFT  = 2'b01;
    localparam logic [1:0] CMD_DIR_RIGHT = 2'b10;
    localparam logic [1:0] CMD_THR_FWD   = 2'b01;
    localparam logic [1:0] CMD_THR_REV   = 2'b10;

    localparam int CMD_LASER_BIT = 4;
    localparam int CMD_THR_LSB   = 2;
    localparam int CMD_DIR_LSB   = 0;

    localparam int DEFAULT_BAUD = 9600;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Opposing buttons pressed together cancel out to 00.
    function automatic logic [7:0] encode_cmd(input logic left, input logic right,
                                              input logic fwd, input logic rev,
                                              input logic laser);
        logic [7:0] c;
        c = '0;
        if (left && !right)
            c[CMD_DIR_LSB +: 2] = CMD_DIR_LEFT;
        else if (right && !left)
            c[CMD_DIR_LSB +: 2] = CMD_DIR_RIGHT;
        if (fwd && !rev)
            c[CMD_THR_LSB +: 2] = CMD_THR_FWD;
        else if (rev && !fwd)
            c[CMD_THR_LSB +: 2] = CMD_THR_REV;
        c[CMD_LASER_BIT] = laser;
        return c;
    endfunction

endpackage

// File: rtl/uart_tx_8n1.sv
// 8N1 serial transmitter, LSB first. A frame is accepted only in IDLE and
// lasts exactly 10*DIV cycles; the baud counter reloads on every bit boundary.
module uart_tx_8n1
    import bt_cmd_pkg::*;
#(
    parameter int DIV = 10416
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       txd,
    output logic       busy
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);

    tx_state_t        state_reg, state_next;
    logic [CNT_W-1:0] baud_reg, baud_next;
    logic [2:0]       bit_reg, bit_next;
    logic [7:0]       shift_reg, shift_next;
    logic             txd_reg, txd_next;
    logic             busy_reg, busy_next;
    logic             baud_end;

    assign baud_end = (baud_reg == BAUD_LAST);
    assign txd      = txd_reg;
    assign busy     = busy_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            baud_reg  <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            txd_reg   <= 1'b1;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            baud_reg  <= baud_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            txd_reg   <= txd_next;
            busy_reg  <= busy_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        baud_next  = baud_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        txd_next   = txd_reg;
        busy_next  = busy_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = START;
                    baud_next  = '0;
                    shift_next = data;
                    txd_next   = 1'b0;
                    busy_next  = 1'b1;
                end
            end
            START: begin
                if (baud_end) begin
                    state_next = DATA;
                    baud_next  = '0;
                    bit_next   = '0;
                    txd_next   = shift_reg[0];
                    shift_next = {1'b0, shift_reg[7:1]};
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_next = '0;
                    if (bit_reg == 3'd7) begin
                        state_next = STOP;
                        txd_next   = 1'b1;
                    end else begin
                        bit_next   = bit_reg + 1'b1;
                        txd_next   = shift_reg[0];
                        shift_next = {1'b0, shift_reg[7:1]};
                    end
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    state_next = IDLE;
                    baud_next  = '0;
                    busy_next  = 1'b0;
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: rtl/bt_cmd_tx.sv
// Controller-side command transmitter: synchronises the buttons and link
// status, encodes the command byte and decides when a frame must be sent.
module bt_cmd_tx
    import bt_cmd_pkg::*;
#(
    parameter int CLK_HZ        = 100_000_000,
    parameter int BAUD          = DEFAULT_BAUD,
    parameter int KEEPALIVE_CYC = 10_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_fwd,
    input  logic       btn_rev,
    input  logic       btn_laser,
    input  logic       link_up,
    output logic       txd,
    output logic       busy,
    output logic [7:0] cmd
);

    localparam int DIV  = CLK_HZ / BAUD;
    localparam int KA_W = (KEEPALIVE_CYC > 2) ? $clog2(KEEPALIVE_CYC) : 1;
    localparam logic [KA_W-1:0] KA_LAST = KA_W'(KEEPALIVE_CYC - 1);

    logic [5:0] raw_in, sync_s;
    assign raw_in = {link_up, btn_laser, btn_rev, btn_fwd, btn_right, btn_left};

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_sync
            logic s1_reg, s2_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    s1_reg <= 1'b0;
                    s2_reg <= 1'b0;
                end else begin
                    s1_reg <= raw_in[gi];
                    s2_reg <= s1_reg;
                end
            end
            assign sync_s[gi] = s2_reg;
        end
    endgenerate

    logic            link_s, link_prev_reg;
    logic [7:0]      enc, cmd_reg, cmd_prev_reg;
    logic            pending_reg, pending_next, pend_set;
    logic [KA_W-1:0] ka_reg, ka_next;
    logic            start, tx_busy;

    assign link_s = sync_s[5];
    assign enc    = encode_cmd(sync_s[0], sync_s[1], sync_s[2], sync_s[3], sync_s[4]);
    assign start  = pending_reg & link_s & ~tx_busy;

    // Expiry fires as the counter steps onto its last value, so that the
    // following start lands exactly KEEPALIVE_CYC cycles after the previous one.
    always_comb begin
        ka_next = ka_reg;
        if (start || !link_s)
            ka_next = '0;
        else if (ka_reg == KA_LAST)
            ka_next = '0;
        else
            ka_next = ka_reg + 1'b1;
    end

    always_comb begin
        pend_set = (cmd_reg != cmd_prev_reg) | (link_s & ~link_prev_reg)
                 | (link_s & (ka_next == KA_LAST));
        // A new request arriving on the start edge survives for a follow-up frame.
        pending_next = pend_set | (pending_reg & ~start);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            link_prev_reg <= 1'b0;
            cmd_reg       <= '0;
            cmd_prev_reg  <= '0;
            pending_reg   <= 1'b0;
            ka_reg        <= '0;
        end else begin
            link_prev_reg <= link_s;
            cmd_reg       <= enc;
            cmd_prev_reg  <= cmd_reg;
            pending_reg   <= pending_next;
            ka_reg        <= ka_next;
        end
    end

    uart_tx_8n1 #(.DIV(DIV)) u_tx (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .data  (cmd_reg),
        .txd   (txd),
        .busy  (tx_busy)
    );

    assign busy = tx_busy;
    assign cmd  = cmd_reg;

endmodule

// File: tb/tb_bt_cmd_tx.sv
// Directed bench for bt_cmd_tx with DIV=10 and a 500-cycle keepalive.
module tb_bt_cmd_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_left, btn_right, btn_fwd, btn_rev, btn_laser, link_up;
    logic       txd, busy;
    logic [7:0] cmd;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int fall_cyc = 0;

    bt_cmd_tx #(.CLK_HZ(1000), .BAUD(100), .KEEPALIVE_CYC(500)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_fwd   (btn_fwd),
        .btn_rev   (btn_rev),
        .btn_laser (btn_laser),
        .link_up   (link_up),
        .txd       (txd),
        .busy      (busy),
        .cmd       (cmd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_fall(input int max_n, output bit found);
        found = 1'b0;
        for (int i = 0; i < max_n; i++) begin
            @(negedge clk);
            if (txd === 1'b0) begin
                found = 1'b1;
                fall_cyc = cyc;
                break;
            end
        end
    endtask

    // Called on the first negedge of the start bit; samples each bit mid-period.
    task automatic rx_bits(output logic [7:0] d, output logic s_ok, output logic p_ok);
        repeat (4) @(negedge clk);
        s_ok = (txd === 1'b0);
        for (int b = 0; b < 8; b++) begin
            repeat (10) @(negedge clk);
            d[b] = txd;
        end
        repeat (10) @(negedge clk);
        p_ok = (txd === 1'b1);
    endtask

    task automatic test_reset;
        rst = 1'b1; link_up = 1'b0;
        btn_left = 1'b0; btn_right = 1'b0; btn_fwd = 1'b0; btn_rev = 1'b0; btn_laser = 1'b0;
        settle(3);
        total++; if (txd !== 1'b1) begin bad++; $display("FAIL reset_txd: got %b want 1", txd); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (cmd !== 8'h00) begin bad++; $display("FAIL reset_cmd: got %h want 00", cmd); end
        rst = 1'b0;
        settle(10);
        total++; if (txd !== 1'b1 || busy !== 1'b0)
            begin bad++; $display("FAIL no_link_idle: got txd=%b busy=%b want 1/0", txd, busy); end
    endtask

    task automatic test_link_frame;
        bit found; int t0, nbusy, nlow;
        logic [7:0] d; logic s_ok, p_ok;
        link_up = 1'b1;
        wait_fall(20, found);
        total++; if (!found) begin bad++; $display("FAIL link_frame_start: got none want frame"); end
        t0 = fall_cyc; nbusy = 0; nlow = 0;
        for (int i = 0; i < 200; i++) begin
            if (busy !== 1'b1) break;
            nbusy++;
            if (txd === 1'b0) nlow++;
            @(negedge clk);
        end
        total++; if (nbusy != 100) begin bad++; $display("FAIL frame_len: got %0d want 100", nbusy); end
        total++; if (nlow != 90) begin bad++; $display("FAIL frame_low_cycles: got %0d want 90", nlow); end
        wait_fall(600, found);
        total++; if (!found || fall_cyc - t0 != 500)
            begin bad++; $display("FAIL keepalive_gap: got %0d want 500", fall_cyc - t0); end
        rx_bits(d, s_ok, p_ok);
        total++; if (d !== 8'h00 || !s_ok || !p_ok)
            begin bad++; $display("FAIL keepalive_data: got %h s=%b p=%b want 00 1 1", d, s_ok, p_ok); end
    endtask

    task automatic test_latency;
        logic early; logic [7:0] d; logic s_ok, p_ok;
        settle(10);
        btn_fwd = 1'b1; btn_left = 1'b1;
        early = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (txd !== 1'b1) early = 1'b1;
        end
        @(negedge clk);
        total++; if (early || txd !== 1'b0)
            begin bad++; $display("FAIL latency4: got early=%b txd=%b want 0/0", early, txd); end
        total++; if (cmd !== 8'h05) begin bad++; $display("FAIL cmd_05: got %h want 05", cmd); end
        rx_bits(d, s_ok, p_ok);
        total++; if (d !== 8'h05 || !s_ok || !p_ok)
            begin bad++; $display("FAIL frame_05: got %h s=%b p=%b want 05 1 1", d, s_ok, p_ok); end
    endtask

    task automatic test_dir_cancel;
        bit found; logic [7:0] d; logic s_ok, p_ok;
        settle(10);
        btn_fwd = 1'b0; btn_left = 1'b1; btn_right = 1'b1; btn_laser = 1'b1;
        wait_fall(10, found);
        total++; if (!found) begin bad++; $display("FAIL cancel_start: got none want frame"); end
        total++; if (cmd !== 8'h10) begin bad++; $display("FAIL cmd_10: got %h want 10", cmd); end
        rx_bits(d, s_ok, p_ok);
        total++; if (d !== 8'h10 || !p_ok)
            begin bad++; $display("FAIL frame_10: got %h p=%b want 10 1", d, p_ok); end
    endtask

    task automatic test_change_in_frame;
        bit found; int f1;
        logic [7:0] d1, d2; logic s1, p1, s2, p2;
        settle(10);
        btn_left = 1'b0; btn_right = 1'b0; btn_laser = 1'b0; btn_fwd = 1'b1;
        wait_fall(10, found);
        f1 = fall_cyc;
        fork
            rx_bits(d1, s1, p1);
            begin
                settle(29); btn_laser = 1'b1;
                settle(30); btn_laser = 1'b0;
            end
        join
        total++; if (!found || d1 !== 8'h04 || !p1)
            begin bad++; $display("FAIL inflight_04: got %h p=%b want 04 1", d1, p1); end
        wait_fall(20, found);
        total++; if (!found || fall_cyc - f1 != 101)
            begin bad++; $display("FAIL b2b_gap: got %0d want 101", fall_cyc - f1); end
        rx_bits(d2, s2, p2);
        total++; if (d2 !== 8'h04 || !s2 || !p2)
            begin bad++; $display("FAIL followup_04: got %h s=%b p=%b want 04 1 1", d2, s2, p2); end
        wait_fall(200, found);
        total++; if (found) begin bad++; $display("FAIL single_followup: got extra frame want none"); end
    endtask

    task automatic test_keepalive_link;
        bit found; int f1;
        logic [7:0] d; logic s_ok, p_ok;
        wait_fall(400, found);
        f1 = fall_cyc;
        total++; if (!found) begin bad++; $display("FAIL ka_first: got none want frame"); end
        rx_bits(d, s_ok, p_ok);
        wait_fall(600, found);
        total++; if (!found || fall_cyc - f1 != 500)
            begin bad++; $display("FAIL ka_steady_gap: got %0d want 500", fall_cyc - f1); end
        fork
            rx_bits(d, s_ok, p_ok);
            begin settle(30); link_up = 1'b0; end
        join
        total++; if (d !== 8'h04 || !s_ok || !p_ok)
            begin bad++; $display("FAIL linkdrop_complete: got %h s=%b p=%b want 04 1 1", d, s_ok, p_ok); end
        wait_fall(700, found);
        total++; if (found) begin bad++; $display("FAIL linkdown_quiet: got frame want none"); end
        link_up = 1'b1;
        wait_fall(20, found);
        total++; if (!found) begin bad++; $display("FAIL linkup_frame: got none want frame"); end
        rx_bits(d, s_ok, p_ok);
        total++; if (d !== 8'h04 || !p_ok)
            begin bad++; $display("FAIL linkup_data: got %h p=%b want 04 1", d, p_ok); end
    endtask

    task automatic test_reset_mid;
        bit found; logic early;
        logic [7:0] d; logic s_ok, p_ok;
        settle(10);
        btn_laser = 1'b1;
        wait_fall(10, found);
        total++; if (!found) begin bad++; $display("FAIL mid_frame_start: got none want frame"); end
        settle(44);
        rst = 1'b1;
        @(negedge clk);
        total++; if (txd !== 1'b1 || busy !== 1'b0 || cmd !== 8'h00)
            begin bad++; $display("FAIL mid_reset: got txd=%b busy=%b cmd=%h want 1 0 00", txd, busy, cmd); end
        settle(2);
        rst = 1'b0;
        early = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (txd !== 1'b1) early = 1'b1;
        end
        total++; if (early) begin bad++; $display("FAIL post_reset_hold: got early frame want idle"); end
        wait_fall(5, found);
        total++; if (!found) begin bad++; $display("FAIL post_reset_frame: got none want frame"); end
        rx_bits(d, s_ok, p_ok);
        total++; if (d !== 8'h14 || !s_ok || !p_ok)
            begin bad++; $display("FAIL post_reset_data: got %h s=%b p=%b want 14 1 1", d, s_ok, p_ok); end
    endtask

    initial begin
        test_reset;
        test_link_frame;
        test_latency;
        test_dir_cancel;
        test_change_in_frame;
        test_keepalive_link;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
